// File: rtl/mod_n_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_n_counter
// Description : Runtime-programmable modulo-N up/down counter.
//               - Synchronous clear, and parallel load that clamps to the modulus.
//               - One-shot (halt at terminal) or free-running wrap mode.
//               - Combinational terminal count for building multi-digit
//                 cascades (next stage en = this stage tc).
// Ports       :
//   clk       in   clock, rising edge active
//   rst       in   synchronous active-high reset
//   en        in   count enable, one step per cycle
//   up        in   direction, 1 = up, 0 = down
//   clr       in   synchronous clear to 0, leaves HALT
//   load      in   parallel load of load_val, clamped to max_q, leaves HALT
//   load_val  in   [WIDTH] load data
//   max_wr    in   write max_in into the modulus register
//   max_in    in   [WIDTH] new terminal value, modulus = max_in + 1
//   oneshot   in   1 = halt at terminal, 0 = wrap
//   q         out  [WIDTH] count value, registered
//   max_q     out  [WIDTH] modulus register, registered
//   tc        out  terminal count, combinational
//   wrap      out  one-cycle pulse after each wrap, registered
//   done      out  high while halted, registered
//   load_err  out  one-cycle pulse after a clamped load, registered
// Revision    : 1.0 - initial release
// ============================================================================
module mod_n_counter #(
    parameter int WIDTH   = 4,
    parameter int RST_MAX = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             max_wr,
    input  logic [WIDTH-1:0] max_in,
    input  logic             oneshot,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] max_q,
    output logic             tc,
    output logic             wrap,
    output logic             done,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] C_RST_MAX = WIDTH'(RST_MAX);
    localparam logic [WIDTH-1:0] C_ZERO    = '0;
    localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);

    localparam logic [0:0] C_ST_RUN  = 1'b0;
    localparam logic [0:0] C_ST_HALT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_max;
    logic             r_wrap;
    logic             r_load_err;

    logic             w_term_up;
    logic             w_term_dn;
    logic             w_above_max;
    logic             w_load_clamp;
    logic             w_halted;

    // Terminal tests use the modulus held before the edge; ">=" on the up
    // side lets a stale q above a freshly shrunk modulus recover in one step.
    assign w_term_up    = (r_q >= r_max);
    assign w_term_dn    = (r_q == C_ZERO);
    assign w_above_max  = (r_q > r_max);
    assign w_load_clamp = (load_val > r_max);
    assign w_halted     = (r_state == C_ST_HALT);

    assign tc = en & ~clr & ~load & ~w_halted & (up ? w_term_up : w_term_dn);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= C_ST_RUN;
            r_q        <= C_ZERO;
            r_max      <= C_RST_MAX;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            // Pulses default low; only a wrap or clamp this edge raises them.
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;

            // Modulus write is independent of the count controls.
            if (max_wr) begin
                r_max <= max_in;
            end

            if (clr) begin
                r_q     <= C_ZERO;
                r_state <= C_ST_RUN;
            end else if (load) begin
                r_state <= C_ST_RUN;
                if (w_load_clamp) begin
                    r_q        <= r_max;
                    r_load_err <= 1'b1;
                end else begin
                    r_q <= load_val;
                end
            end else if (en && (r_state == C_ST_RUN)) begin
                if (up) begin
                    if (w_term_up) begin
                        if (oneshot) begin
                            r_q     <= r_max;
                            r_state <= C_ST_HALT;
                        end else begin
                            r_q    <= C_ZERO;
                            r_wrap <= 1'b1;
                        end
                    end else begin
                        r_q <= r_q + C_ONE;
                    end
                end else begin
                    if (w_above_max) begin
                        // Out-of-range value snaps down to the top; not a wrap.
                        r_q <= r_max;
                    end else if (w_term_dn) begin
                        if (oneshot) begin
                            r_state <= C_ST_HALT;
                        end else begin
                            r_q    <= r_max;
                            r_wrap <= 1'b1;
                        end
                    end else begin
                        r_q <= r_q - C_ONE;
                    end
                end
            end
        end
    end

    assign q        = r_q;
    assign max_q    = r_max;
    assign wrap     = r_wrap;
    assign done     = w_halted;
    assign load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_mod_n_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_n_counter
// Description : Self-checking bench for mod_n_counter. A behavioural model
//               tracks the count with integer arithmetic; directed scenarios
//               are followed by random stimulus and a two-stage cascade.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_n_counter;

    localparam int WIDTH   = 4;
    localparam int RST_MAX = 9;

    logic             clk;
    logic             rst, en, up, clr, load, max_wr, oneshot;
    logic [WIDTH-1:0] load_val, max_in;
    logic [WIDTH-1:0] q, max_q;
    logic             tc, wrap, done, load_err;

    // Cascade pair signals
    logic             c_rst, c_en;
    logic [WIDTH-1:0] lo_q, lo_max, hi_q, hi_max;
    logic             lo_tc, lo_wrap, lo_done, lo_lerr;
    logic             hi_tc, hi_wrap, hi_done, hi_lerr;

    int n_chk = 0;
    int n_err = 0;
    int wrap_seen;

    // Behavioural model state
    int m_q, m_max;
    bit m_halt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mod_n_counter #(.WIDTH(WIDTH), .RST_MAX(RST_MAX)) u_dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .max_wr(max_wr), .max_in(max_in), .oneshot(oneshot),
        .q(q), .max_q(max_q), .tc(tc), .wrap(wrap), .done(done), .load_err(load_err)
    );

    mod_n_counter #(.WIDTH(WIDTH), .RST_MAX(RST_MAX)) u_lo (
        .clk(clk), .rst(c_rst), .en(c_en), .up(1'b1), .clr(1'b0), .load(1'b0),
        .load_val('0), .max_wr(1'b0), .max_in('0), .oneshot(1'b0),
        .q(lo_q), .max_q(lo_max), .tc(lo_tc), .wrap(lo_wrap), .done(lo_done),
        .load_err(lo_lerr)
    );

    mod_n_counter #(.WIDTH(WIDTH), .RST_MAX(RST_MAX)) u_hi (
        .clk(clk), .rst(c_rst), .en(lo_tc), .up(1'b1), .clr(1'b0), .load(1'b0),
        .load_val('0), .max_wr(1'b0), .max_in('0), .oneshot(1'b0),
        .q(hi_q), .max_q(hi_max), .tc(hi_tc), .wrap(hi_wrap), .done(hi_done),
        .load_err(hi_lerr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check tc against the model, predict the edge,
    // then check all registered outputs just after it.
    task automatic cyc();
        int nq, nmax;
        bit nh, nw, nl, etc;
        #1;
        etc = en && !clr && !load && !m_halt && (up ? (m_q >= m_max) : (m_q == 0));
        chk("tc", {31'd0, tc}, {31'd0, etc});
        nq = m_q; nmax = m_max; nh = m_halt; nw = 0; nl = 0;
        if (max_wr) nmax = int'(max_in);
        if (rst) begin
            nq = 0; nmax = RST_MAX; nh = 0;
        end else if (clr) begin
            nq = 0; nh = 0;
        end else if (load) begin
            nh = 0;
            if (int'(load_val) > m_max) begin nq = m_max; nl = 1; end
            else nq = int'(load_val);
        end else if (en && !m_halt) begin
            if (up) begin
                if (m_q >= m_max) begin
                    if (oneshot) begin nq = m_max; nh = 1; end
                    else begin nq = 0; nw = 1; end
                end else nq = m_q + 1;
            end else begin
                if (m_q > m_max) nq = m_max;
                else if (m_q == 0) begin
                    if (oneshot) nh = 1;
                    else begin nq = m_max; nw = 1; end
                end else nq = m_q - 1;
            end
        end
        @(posedge clk);
        #1;
        m_q = nq; m_max = nmax; m_halt = nh;
        chk("q", 32'(q), nq);
        chk("max_q", 32'(max_q), nmax);
        chk("wrap", {31'd0, wrap}, {31'd0, nw});
        chk("done", {31'd0, done}, {31'd0, nh});
        chk("load_err", {31'd0, load_err}, {31'd0, nl});
        if (wrap) wrap_seen++;
    endtask

    task automatic idle_inputs();
        rst = 0; en = 0; up = 1; clr = 0; load = 0; max_wr = 0;
        load_val = '0; max_in = '0;
    endtask

    int seq2[7] = '{5, 4, 3, 2, 1, 0, 5};

    initial begin
        idle_inputs();
        oneshot = 0;
        rst = 1;
        c_rst = 1; c_en = 0;
        @(posedge clk);
        #1;
        m_q = 0; m_max = RST_MAX; m_halt = 0;
        chk("rst_q", 32'(q), 0);
        chk("rst_max_q", 32'(max_q), RST_MAX);
        chk("rst_wrap", {31'd0, wrap}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_load_err", {31'd0, load_err}, 0);

        // Default modulus, count up 25 cycles
        idle_inputs(); en = 1; up = 1; wrap_seen = 0;
        for (int i = 0; i < 25; i++) cyc();
        chk("up25_q", 32'(q), 5);
        chk("up25_wraps", wrap_seen, 2);

        // Modulus 6 counting down from 0
        idle_inputs(); clr = 1; max_wr = 1; max_in = 4'd5;
        cyc();
        idle_inputs(); en = 1; up = 0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("dn6_seq", 32'(q), seq2[i]);
        end

        // Shrink modulus below a stale q, then count up / down
        for (int d = 0; d < 2; d++) begin
            idle_inputs(); max_wr = 1; max_in = 4'd15; cyc();
            idle_inputs(); load = 1; load_val = 4'd12; cyc();
            idle_inputs(); max_wr = 1; max_in = 4'd7; cyc();
            idle_inputs(); en = 1; up = (d == 0);
            cyc();
            chk("shrink_q", 32'(q), (d == 0) ? 0 : 7);
            chk("shrink_wrap", {31'd0, wrap}, (d == 0) ? 1 : 0);
        end

        // One-shot with max_q=3
        idle_inputs(); max_wr = 1; max_in = 4'd3; clr = 1; cyc();
        idle_inputs(); oneshot = 1; en = 1; up = 1;
        for (int i = 0; i < 6; i++) cyc();
        chk("os_q", 32'(q), 3);
        chk("os_done", {31'd0, done}, 1);
        oneshot = 0; cyc();
        chk("os_stay_halt", {31'd0, done}, 1);
        clr = 1; cyc();
        chk("os_clr_done", {31'd0, done}, 0);
        clr = 0; cyc(); cyc();

        // Clamped load, load+clr, rst+load
        idle_inputs(); max_wr = 1; max_in = 4'd9; cyc();
        idle_inputs(); load = 1; load_val = 4'd11; cyc();
        chk("clamp_q", 32'(q), 9);
        chk("clamp_err", {31'd0, load_err}, 1);
        idle_inputs(); cyc();
        idle_inputs(); load = 1; load_val = 4'd4; clr = 1; cyc();
        idle_inputs(); load = 1; load_val = 4'd4; rst = 1; en = 1; cyc();

        // Mod-1
        idle_inputs(); max_wr = 1; max_in = 4'd0; cyc();
        idle_inputs(); en = 1;
        for (int i = 0; i < 4; i++) begin up = i[0]; cyc(); end

        // Random stimulus
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 79) == 0);
            clr      = ($urandom_range(0, 15) == 0);
            load     = ($urandom_range(0, 9) == 0);
            load_val = 4'($urandom_range(0, 15));
            max_wr   = ($urandom_range(0, 19) == 0);
            max_in   = 4'($urandom_range(0, 15));
            en       = ($urandom_range(0, 3) != 0);
            up       = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) oneshot = ~oneshot;
            cyc();
        end

        // Two-stage cascade, both mod-10
        @(posedge clk); #1;
        c_rst = 0; c_en = 1;
        for (int i = 1; i <= 120; i++) begin
            @(posedge clk); #1;
            chk("cas_lo", 32'(lo_q), i % 10);
            chk("cas_hi", 32'(hi_q), (i / 10) % 10);
            chk("cas_hi_wrap", {31'd0, hi_wrap}, (i % 100 == 0) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
